// File: rtl/pkt_router_n.sv
// Header-steered packet router: one input byte stream fans out into NPORTS byte FIFOs with offer/proceed handoff.
// Define PKT_ROUTER_STATS_EN to add the saturating drop_cnt output.
//
// state     | meaning
// IN_IDLE   | waiting for a header byte
// IN_LOAD   | writing accepted payload into FIFO[in_dest]
// IN_DROP   | swallowing payload of a rejected packet
// OUT_IDLE  | nothing complete to offer
// OUT_OFFER | head length on newdata_len, waiting for proceed
// OUT_SEND  | streaming head packet onto data_out
module pkt_router_n #(
   parameter int NPORTS = 4,
   parameter int DW     = 8,
   parameter int LEN_W  = 5,
   parameter int DEPTH  = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    bnd_plse,
   input  logic [DW-1:0]           data_in,
   output logic                    ack,
   output logic [NPORTS*DW-1:0]    data_out,
   output logic [NPORTS*LEN_W-1:0] newdata_len,
   input  logic [NPORTS-1:0]       proceed
`ifdef PKT_ROUTER_STATS_EN
   ,
   output logic [15:0]             drop_cnt
`endif
);

   localparam int PW   = $clog2(NPORTS);
   localparam int DSTW = DW - LEN_W;
   localparam int AW   = $clog2(DEPTH);
   localparam int CW   = AW + 1;
   localparam int FW   = CW + 1;

   localparam logic [1:0] IN_IDLE   = 2'd0;
   localparam logic [1:0] IN_LOAD   = 2'd1;
   localparam logic [1:0] IN_DROP   = 2'd2;
   localparam logic [1:0] OUT_IDLE  = 2'd0;
   localparam logic [1:0] OUT_OFFER = 2'd1;
   localparam logic [1:0] OUT_SEND  = 2'd2;

   logic [LEN_W-1:0]           hdr_len;
   logic [DSTW-1:0]            hdr_dest;
   logic [PW-1:0]              hdr_port;
   logic                       dest_ok;
   logic                       hdr_ok;
   logic [CW-1:0]              sel_cnt;
   logic                       sel_rd;
   logic [FW-1:0]              room;
   logic [1:0]                 in_state;
   logic [LEN_W-1:0]           in_left;
   logic [LEN_W-1:0]           in_len;
   logic [PW-1:0]              in_dest;
   logic [NPORTS-1:0][CW-1:0]  fill;
   logic [NPORTS-1:0]          rd_en;

   // The whole field above the length is the destination, so out-of-range ports are detectable.
   assign hdr_len  = data_in[LEN_W-1:0];
   assign hdr_dest = data_in[DW-1:LEN_W];
   assign hdr_port = hdr_dest[PW-1:0];
   assign dest_ok  = {{(32-DSTW){1'b0}}, hdr_dest} < 32'(NPORTS);

   always_comb begin
      sel_cnt = '0;
      sel_rd  = 1'b0;
      for (int i = 0; i < NPORTS; i++) begin
         if (hdr_port == PW'(i)) begin
            sel_cnt = fill[i];
            sel_rd  = rd_en[i];
         end
      end
   end

   // A byte leaving the target FIFO on the header cycle already counts as free room.
   assign room   = FW'(DEPTH) - FW'(sel_cnt) + FW'(sel_rd);
   assign hdr_ok = dest_ok && (hdr_len != '0) && (room >= FW'(hdr_len));

   always_ff @(posedge clk) begin
      if (reset) begin
         in_state <= IN_IDLE;
         in_left  <= '0;
         in_len   <= '0;
         in_dest  <= '0;
         ack      <= 1'b0;
      end else begin
         ack <= 1'b0;
         case (in_state)
            IN_IDLE: begin
               if (bnd_plse) begin
                  in_len  <= hdr_len;
                  in_left <= hdr_len;
                  in_dest <= hdr_port;
                  if (hdr_ok) begin
                     in_state <= IN_LOAD;
                     ack      <= 1'b1;
                  end else if (hdr_len != '0) begin
                     in_state <= IN_DROP;
                  end
               end
            end
            IN_LOAD, IN_DROP: begin
               in_left <= in_left - LEN_W'(1);
               if (in_left == LEN_W'(1))
                  in_state <= IN_IDLE;
            end
            default: in_state <= IN_IDLE;
         endcase
      end
   end

`ifdef PKT_ROUTER_STATS_EN
   logic drop_evt;
   assign drop_evt = (in_state == IN_IDLE) && bnd_plse && !hdr_ok;

   always_ff @(posedge clk) begin
      if (reset)
         drop_cnt <= '0;
      else if (drop_evt && (drop_cnt != 16'hFFFF))
         drop_cnt <= drop_cnt + 16'd1;
   end
`endif

   for (genvar p = 0; p < NPORTS; p++) begin : g_port
      logic [DW-1:0]    mem [DEPTH];
      logic [LEN_W-1:0] lq  [DEPTH];
      logic [AW-1:0]    wp;
      logic [AW-1:0]    rp;
      logic [AW-1:0]    lwp;
      logic [AW-1:0]    lrp;
      logic [CW-1:0]    cnt;
      logic [CW-1:0]    lcnt;
      logic [1:0]       st;
      logic [LEN_W-1:0] left;
      logic             wr;
      logic             push;
      logic             rd;
      logic             pop;

      assign wr   = (in_state == IN_LOAD) && (in_dest == PW'(p));
      assign push = wr && (in_left == LEN_W'(1));
      assign rd   = (st == OUT_SEND);
      assign pop  = (st == OUT_OFFER) && proceed[p];

      assign rd_en[p] = rd;
      assign fill[p]  = cnt;
      assign data_out[p*DW +: DW]          = rd ? mem[rp] : '0;
      assign newdata_len[p*LEN_W +: LEN_W] = (st == OUT_OFFER) ? lq[lrp] : '0;

      always_ff @(posedge clk) begin
         if (wr)
            mem[wp] <= data_in;
         if (push)
            lq[lwp] <= in_len;
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            wp   <= '0;
            rp   <= '0;
            lwp  <= '0;
            lrp  <= '0;
            cnt  <= '0;
            lcnt <= '0;
            st   <= OUT_IDLE;
            left <= '0;
         end else begin
            if (wr)
               wp <= wp + AW'(1);
            if (rd)
               rp <= rp + AW'(1);
            if (push)
               lwp <= lwp + AW'(1);
            if (pop)
               lrp <= lrp + AW'(1);
            cnt  <= cnt + CW'(wr) - CW'(rd);
            lcnt <= lcnt + CW'(push) - CW'(pop);
            // A length pushed this edge is offered straight away.
            case (st)
               OUT_IDLE: begin
                  if ((lcnt != '0) || push)
                     st <= OUT_OFFER;
               end
               OUT_OFFER: begin
                  if (proceed[p]) begin
                     st   <= OUT_SEND;
                     left <= lq[lrp];
                  end
               end
               OUT_SEND: begin
                  left <= left - LEN_W'(1);
                  if (left == LEN_W'(1))
                     st <= OUT_IDLE;
               end
               default: st <= OUT_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pkt_router_n.sv
// Bench for pkt_router_n: directed scenarios plus randomized traffic, checked every cycle
// against a queue-based packet model of the router.
module tb_pkt_router_n;
   localparam int NP    = 4;
   localparam int DW    = 8;
   localparam int LW    = 5;
   localparam int DEPTH = 32;

   logic             clk      = 1'b0;
   logic             reset    = 1'b1;
   logic             bnd_plse = 1'b0;
   logic [DW-1:0]    data_in  = '0;
   logic [NP-1:0]    proceed  = '0;
   logic             ack;
   logic [NP*DW-1:0] data_out;
   logic [NP*LW-1:0] newdata_len;
`ifdef PKT_ROUTER_STATS_EN
   logic [15:0]      drop_cnt;
`endif

   pkt_router_n #(.NPORTS(NP), .DW(DW), .LEN_W(LW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .bnd_plse   (bnd_plse),
      .data_in    (data_in),
      .ack        (ack),
      .data_out   (data_out),
      .newdata_len(newdata_len),
      .proceed    (proceed)
`ifdef PKT_ROUTER_STATS_EN
      ,
      .drop_cnt   (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: accepted bytes and completed lengths per port, plus handoff phase per port
   // (0 nothing offered, 1 offering head, 2 streaming head).
   logic [7:0] byte_q [NP][$];
   int         len_q  [NP][$];
   int         mode      [NP];
   int         send_left [NP];
   int         in_left = 0;
   bit         in_acc  = 1'b0;
   int         in_dest = 0;
   int         in_len  = 0;
   bit         exp_ack = 1'b0;
   int         drops   = 0;
   bit         started = 1'b0;

   bit         rnd_prc = 1'b0;
   int         prc_pct = 50;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int d;
      int l;
      bit ok;
      bit rd [NP];
      if (reset) begin
         for (int p = 0; p < NP; p++) begin
            byte_q[p].delete();
            len_q[p].delete();
            mode[p]      = 0;
            send_left[p] = 0;
         end
         in_left = 0;
         in_acc  = 1'b0;
         exp_ack = 1'b0;
         drops   = 0;
         started = 1'b1;
         return;
      end
      if (!started)
         return;
      for (int p = 0; p < NP; p++)
         rd[p] = (mode[p] == 2);
      exp_ack = 1'b0;
      if (in_left == 0) begin
         if (bnd_plse) begin
            d  = int'(data_in[DW-1:LW]);
            l  = int'(data_in[LW-1:0]);
            ok = 1'b0;
            if (d < NP && l != 0)
               ok = (DEPTH - byte_q[d].size() + (rd[d] ? 1 : 0)) >= l;
            in_left = l;
            in_acc  = ok;
            if (ok) begin
               in_dest = d;
               in_len  = l;
               exp_ack = 1'b1;
            end else if (drops < 65535) begin
               drops++;
            end
         end
      end else begin
         if (in_acc)
            byte_q[in_dest].push_back(data_in);
         in_left--;
         if (in_left == 0 && in_acc)
            len_q[in_dest].push_back(in_len);
      end
      for (int p = 0; p < NP; p++) begin
         case (mode[p])
            0: if (len_q[p].size() != 0) mode[p] = 1;
            1: if (proceed[p]) begin
                  send_left[p] = len_q[p].pop_front();
                  mode[p] = 2;
               end
            default: begin
               void'(byte_q[p].pop_front());
               send_left[p]--;
               if (send_left[p] == 0) mode[p] = 0;
            end
         endcase
      end
   endtask

   // Monitor: compare what the DUT presents against the model, then advance the model
   // with the inputs that the coming rising edge will sample.
   always @(negedge clk) begin : mon
      logic [NP*DW-1:0] e_data;
      logic [NP*LW-1:0] e_len;
      if (started) begin
         e_data = '0;
         e_len  = '0;
         for (int p = 0; p < NP; p++) begin
            if (mode[p] == 2) e_data[p*DW +: DW] = byte_q[p][0];
            if (mode[p] == 1) e_len[p*LW +: LW]  = LW'(len_q[p][0]);
         end
         chk("ack", {63'd0, ack}, {63'd0, exp_ack});
         chk("data_out", {32'd0, data_out}, {32'd0, e_data});
         chk("newdata_len", {44'd0, newdata_len}, {44'd0, e_len});
`ifdef PKT_ROUTER_STATS_EN
         chk("drop_cnt", {48'd0, drop_cnt}, 64'(drops));
`endif
      end
      model_step();
   end

   task automatic tick();
      if (rnd_prc)
         for (int p = 0; p < NP; p++)
            proceed[p] = ($urandom_range(0, 99) < prc_pct);
      @(posedge clk);
      #1;
   endtask

   task automatic send_pkt(input int dest, input int len, input bit noisy, input int base);
      bnd_plse = 1'b1;
      data_in  = 8'((dest << LW) | len);
      tick();
      for (int i = 0; i < len; i++) begin
         bnd_plse = noisy && ($urandom_range(0, 7) == 0);
         data_in  = (base < 0) ? 8'($urandom) : 8'(base + i);
         tick();
      end
      bnd_plse = 1'b0;
      data_in  = '0;
   endtask

   initial begin
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // Header 0x43 -> port 2, three bytes, explicit timing checks.
      bnd_plse = 1'b1;
      data_in  = 8'h43;
      tick();
      chk("hdr43_ack", {63'd0, ack}, 64'd1);
      bnd_plse = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data_in = 8'hA1 + 8'(i);
         tick();
      end
      data_in = '0;
      chk("hdr43_offer", {59'd0, newdata_len[2*LW +: LW]}, 64'd3);
      repeat (2) tick();
      proceed[2] = 1'b1;
      tick();
      proceed[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("hdr43_byte", {56'd0, data_out[2*DW +: DW]}, 64'(8'hA1 + i));
         tick();
      end
      repeat (3) tick();

      // Out-of-range destination, then zero-length header followed immediately by a real one.
      send_pkt(5, 2, 1'b0, 8'h10);
      repeat (3) tick();
      send_pkt(1, 0, 1'b0, -1);
      send_pkt(1, 2, 1'b0, 8'h20);
      proceed = '1;
      repeat (8) tick();
      proceed = '0;

      // Port 0 filled to 30 bytes: 3-byte packet dropped, then accepted with a read on the header cycle.
      send_pkt(0, 15, 1'b0, 8'h30);
      send_pkt(0, 15, 1'b0, 8'h50);
      bnd_plse = 1'b1;
      data_in  = 8'h03;
      tick();
      chk("full_drop_ack", {63'd0, ack}, 64'd0);
      bnd_plse = 1'b0;
      repeat (3) tick();
      proceed[0] = 1'b1;
      tick();
      proceed[0] = 1'b0;
      bnd_plse = 1'b1;
      data_in  = 8'h03;
      tick();
      chk("freed_accept_ack", {63'd0, ack}, 64'd1);
      bnd_plse = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data_in = 8'h70 + 8'(i);
         tick();
      end
      proceed = '1;
      repeat (60) tick();

      // Back-to-back packets to ports 1 and 3 with proceed held high.
      send_pkt(1, 4, 1'b0, 8'h80);
      send_pkt(3, 5, 1'b0, 8'h90);
      send_pkt(1, 2, 1'b0, 8'hB0);
      send_pkt(3, 1, 1'b0, 8'hC0);
      repeat (12) tick();
      proceed = '0;

      // Reset during byte 2 of a 4-byte load.
      bnd_plse = 1'b1;
      data_in  = 8'h64;
      tick();
      bnd_plse = 1'b0;
      data_in  = 8'hD1;
      tick();
      data_in  = 8'hD2;
      reset    = 1'b1;
      tick();
      reset    = 1'b0;
      chk("rst_load_ack", {63'd0, ack}, 64'd0);
      chk("rst_load_len", {44'd0, newdata_len}, 64'd0);
      data_in = 8'hD3;
      tick();
      data_in = 8'hD4;
      tick();
      data_in = '0;
      repeat (3) tick();

      // Reset during a send, with a second packet still queued.
      send_pkt(0, 6, 1'b0, 8'hE0);
      send_pkt(0, 2, 1'b0, 8'hF0);
      tick();
      proceed[0] = 1'b1;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_send_data", {32'd0, data_out}, 64'd0);
      chk("rst_send_len", {44'd0, newdata_len}, 64'd0);
      repeat (5) tick();
      proceed = '0;

      // Randomized traffic, including noisy boundary pulses inside payloads.
      rnd_prc = 1'b1;
      for (int k = 0; k < 300; k++) begin
         int d;
         int l;
         if (k % 100 == 0)
            prc_pct = $urandom_range(5, 90);
         d = $urandom_range(0, 5);
         l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 31);
         send_pkt(d, l, 1'b1, -1);
         repeat ($urandom_range(0, 2)) tick();
         if (k == 150) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
         end
      end
      rnd_prc = 1'b0;
      proceed = '1;
      repeat (200) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run still active at t=%0t, expected finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
